// File: rtl/refill_arbiter_pkg.sv
// Shared constants for the cache refill arbiter: FSM state encodings,
// requester ids and burst/block geometry.
package refill_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Requester ids, also used as the value of last_served
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Burst geometry: four 32-bit beats make one 128-bit block
    localparam int BEATS      = 4;
    localparam int WORD_BITS  = 32;
    localparam int BLOCK_BITS = BEATS * WORD_BITS;

endpackage

// File: rtl/refill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter between the I-cache and D-cache miss requests.
// A decision is only taken while en is high; the winner is remembered in
// last_served so that the loser of a tie is preferred next time.
module rr_arbiter2
    import refill_arbiter_pkg::*;
(
    input  logic clk_inv,
    input  logic nrst,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic grant_valid,
    output logic winner
);

    logic last_served;

    // Pick a winner: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_valid = en && (req_i || req_d);
        winner      = REQ_I;
        if (req_i && req_d) begin
            winner = (last_served == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            winner = REQ_D;
        end
    end

    // Remember the granted side; reset to D so that I wins the first tie
    always_ff @(posedge clk_inv) begin
        if (!nrst) begin
            last_served <= REQ_D;
        end else if (grant_valid) begin
            last_served <= winner;
        end
    end

endmodule

// File: rtl/refill_arbiter.sv
// Refill arbiter: shares the main-memory read port between the I-cache and
// D-cache miss paths. Grants one side round-robin, issues a 4-beat word burst
// for the missed block and assembles it into a 128-bit line.
// Optional feature macro: CRITICAL_WORD_FIRST_EN - when defined the burst
// starts at the missed word and wraps; otherwise it always runs 0,1,2,3.
// Either way every word lands in its own slot of o_data_block.
module refill_arbiter
    import refill_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                    clk_inv,
    input  logic                    nrst,
    input  logic                    i_req_i,
    input  logic [ADDR_BITS-3:0]    i_addr_i,
    input  logic                    i_req_d,
    input  logic [ADDR_BITS-3:0]    i_addr_d,
    input  logic                    i_ready_mm,
    input  logic [WORD_BITS-1:0]    i_data_from_mem,
    output logic                    o_mem_en,
    output logic [ADDR_BITS-3:0]    o_addr_to_mem,
    output logic                    o_gnt_i,
    output logic                    o_gnt_d,
    output logic [BLOCK_BITS-1:0]   o_data_block,
    output logic                    o_done_i,
    output logic                    o_done_d,
    output logic                    o_busy
);

    logic [1:0]             state;
    logic                   gnt_i;
    logic                   gnt_d;
    logic [ADDR_BITS-5:0]   base;
    logic [1:0]             offset;
    logic [1:0]             count;
    logic [1:0]             beat_idx;
    logic [WORD_BITS-1:0]   slot [BEATS];
    logic                   arb_valid;
    logic                   arb_winner;
    logic                   beat_accept;

    rr_arbiter2 u_arb (
        .clk_inv     (clk_inv),
        .nrst        (nrst),
        .en          (state == ST_IDLE),
        .req_i       (i_req_i),
        .req_d       (i_req_d),
        .grant_valid (arb_valid),
        .winner      (arb_winner)
    );

`ifdef CRITICAL_WORD_FIRST_EN
    // Start at the missed word and wrap around the block
    assign beat_idx = offset + count;
`else
    // Fixed ascending order; the missed-word offset does not affect the burst
    logic unused_offset;
    assign unused_offset = ^offset;
    assign beat_idx      = count;
`endif

    assign beat_accept = (state == ST_FILL) && i_ready_mm;

    // Main FSM plus grant, latched address, beat counter and block buffer
    always_ff @(posedge clk_inv) begin
        if (!nrst) begin
            state  <= ST_IDLE;
            gnt_i  <= 1'b0;
            gnt_d  <= 1'b0;
            base   <= '0;
            offset <= '0;
            count  <= '0;
            for (int k = 0; k < BEATS; k++) begin
                slot[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state <= ST_GRANT;
                        gnt_i <= (arb_winner == REQ_I);
                        gnt_d <= (arb_winner == REQ_D);
                    end
                end
                ST_GRANT: begin
                    if (gnt_i) begin
                        base   <= i_addr_i[ADDR_BITS-3:2];
                        offset <= i_addr_i[1:0];
                    end else begin
                        base   <= i_addr_d[ADDR_BITS-3:2];
                        offset <= i_addr_d[1:0];
                    end
                    count <= '0;
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    if (beat_accept) begin
                        slot[beat_idx] <= i_data_from_mem;
                        count          <= count + 2'd1;
                        if (count == 2'd3) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    gnt_i <= 1'b0;
                    gnt_d <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the current state and the latched grant/address
    always_comb begin
        o_mem_en      = (state == ST_FILL);
        o_addr_to_mem = (state == ST_FILL) ? {base, beat_idx} : '0;
        o_gnt_i       = gnt_i;
        o_gnt_d       = gnt_d;
        o_done_i      = (state == ST_DONE) && gnt_i;
        o_done_d      = (state == ST_DONE) && gnt_d;
        o_busy        = (state != ST_IDLE);
        o_data_block  = {slot[0], slot[1], slot[2], slot[3]};
    end

endmodule
